axi4_mem_responder: RTL and testbench
=====================================

Name: axi4_mem_responder

Overview:
- AXI4 slave memory responder with a 64-bit data path. It is the responder end of the Top io_mem_axi master port.
- It stands in for the PS DDR path in board bring-up and in simulation. It holds a register-array memory of 2^ADDR_WIDTH bytes.
- It handles one transaction at a time, supports INCR/FIXED bursts, and round-robins between reads and writes.

Parameters:
- ADDR_WIDTH, 16: byte-address bits used. Upper address bits are ignored, so accesses alias modulo 2^ADDR_WIDTH.
- ID_WIDTH, 6: AXI ID width.

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address ready
- aw_addr  in  32  write byte address
- aw_id  in  ID_WIDTH  write ID
- aw_len  in  8  beats minus 1
- aw_size  in  3  log2 bytes per beat, 0..3
- aw_burst  in  2  0=FIXED, 1=INCR, 2/3=unsupported
- w_valid / w_ready  in / out  1  write data handshake
- w_data  in  64  write data
- w_strb  in  8  byte enables
- w_last  in  1  final write beat
- b_valid / b_ready  out / in  1  write response handshake
- b_id  out  ID_WIDTH  echoes aw_id
- b_resp  out  2  0=OKAY, 2=SLVERR
- ar_valid / ar_ready  in / out  1  read address handshake
- ar_addr  in  32  read byte address
- ar_id  in  ID_WIDTH  read ID
- ar_len  in  8  beats minus 1
- ar_size  in  3  log2 bytes per beat
- ar_burst  in  2  burst type
- r_valid / r_ready  out / in  1  read data handshake
- r_id  out  ID_WIDTH  echoes ar_id
- r_data  out  64  read data
- r_resp  out  2  0=OKAY, 2=SLVERR
- r_last  out  1  final read beat

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; write priority flag prio_wr=0 (read favoured).
  - All valid and ready outputs are 0; b_resp, r_resp, r_data, r_id, b_id and r_last are 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst at once. No response is issued for it.
- States: IDLE, RD_BURST, WR_DATA, WR_RESP.
- IDLE:
  - ar_ready = !prio_wr || !aw_valid.
  - aw_ready = prio_wr || !ar_valid.
  - Both ready signals depend combinationally only on the state, prio_wr and the valid inputs.
  - w_ready=0 and r_valid=0.
  - On an ar handshake: latch id, addr, len, size and burst; go to RD_BURST; set prio_wr=1.
  - On an aw handshake: latch the same fields; go to WR_DATA; set prio_wr=0.
  - The two handshakes can never coincide.
- Address stepping:
  - Word index = addr[ADDR_WIDTH-1:3].
  - INCR: next addr = (addr & ~(2^size-1)) + 2^size.
  - FIXED: addr does not change.
  - Wrap-around past 2^ADDR_WIDTH-1 silently goes to 0.
- Error response:
  - burst=2 or 3, or size>3, gives resp=SLVERR on every beat / on the B response.
  - Writes with an error response are not committed; reads with an error response return r_data=0.
  - Beat count still follows len.
- RD_BURST:
  - r_valid=1 starting the cycle after the ar handshake. Latency is 1 cycle from handshake to first valid beat.
  - r_data = mem[word], full 64 bits, with no lane masking for size<3.
  - r_last=1 when the beat counter equals len.
  - The beat advances only when r_valid && r_ready. The next beat's data is presented the following cycle with no bubble.
  - While r_ready=0, r_data, r_resp and r_last stay stable.
  - After the final beat handshake: go to IDLE, r_valid=0.
- WR_DATA:
  - w_ready=1.
  - On each w handshake, byte lanes with w_strb[i]=1 are written to mem[word].
  - The counter reaches len on the final beat; the state then goes to WR_RESP.
  - If w_last does not match the final-beat position on any beat, b_resp=SLVERR, but the data is still written.
  - Write data arriving before aw is accepted is stalled (w_ready=0 outside WR_DATA).
- WR_RESP:
  - b_valid=1 the cycle after the final w handshake, with b_id equal to the latched id.
  - b_valid is held until b_ready; the state then goes to IDLE.
- Same-cycle write-then-read to the same word, in back-to-back transactions: the read returns the new data.

Test Plan:
- INCR write of len=3 to 0x100 with data 0x11..,0x22..,0x33..,0x44.. and strb=0xFF; then INCR read of len=3 from 0x100 -> r_data matches beats in order, r_last only on beat 3, r_resp=0, and r_id echoes ar_id=0x2A.
- Write to 0x200 with strb=0x0F and data 0xAAAAAAAA_BBBBBBBB after memory holds 0xFFFFFFFF_FFFFFFFF -> a read returns 0xFFFFFFFF_BBBBBBBB.
- aw_valid and ar_valid asserted together from reset -> read is granted first. Both asserted again -> write is granted, alternating thereafter.
- Read of len=7 with r_ready toggling 1,0,0,1 -> every beat is delivered exactly once, data stays stable while stalled, and r_valid deasserts the cycle after the final handshake.
- aw_burst=2 write to 0x300 -> b_resp=2 and memory is unchanged. FIXED read of len=2 at 0x308 -> three identical beats.
- reset_n pulled low mid read burst at beat 2 -> r_valid=0 immediately. After release, a new read of 0x100 returns the previously written data.

Source files
------------

// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory responder: 64-bit data path, byte-addressed register-array
// memory of 2^ADDR_WIDTH bytes, one transaction at a time, INCR/FIXED bursts,
// round-robin arbitration between the read and write address channels.
module axi4_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [31:0]         aw_addr,
  input  logic [ID_WIDTH-1:0] aw_id,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [63:0]         w_data,
  input  logic [7:0]          w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_WIDTH-1:0] b_id,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [31:0]         ar_addr,
  input  logic [ID_WIDTH-1:0] ar_id,
  input  logic [7:0]          ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [ID_WIDTH-1:0] r_id,
  output logic [63:0]         r_data,
  output logic [1:0]          r_resp,
  output logic                r_last
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_DATA  = 2'd2;
  localparam logic [1:0] WR_RESP  = 2'd3;

  localparam int WORDS = 2 ** (ADDR_WIDTH - 3);

  logic [63:0]         mem [0:WORDS-1];

  logic [1:0]          state;
  logic                prio_wr;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          cnt;
  logic                last_err;

  logic                ar_hs;
  logic                aw_hs;
  logic                w_hs;
  logic                r_hs;
  logic                bad_q;
  logic                final_beat;
  logic [31:0]         step;
  logic [31:0]         next_addr;
  logic [ADDR_WIDTH-4:0] word;

  // Address-channel readies: round-robin between the two channels while idle,
  // and held low while reset is asserted.
  always_comb begin
    ar_ready = reset_n && (state == IDLE) && (!prio_wr || !aw_valid);
    aw_ready = reset_n && (state == IDLE) && (prio_wr || !ar_valid);
  end

  // Handshake decodes, burst error detection and next-address computation.
  always_comb begin
    ar_hs      = ar_valid && ar_ready;
    aw_hs      = aw_valid && aw_ready;
    w_ready    = (state == WR_DATA);
    w_hs       = w_valid && w_ready;
    r_valid    = (state == RD_BURST);
    r_hs       = r_valid && r_ready;
    b_valid    = (state == WR_RESP);
    bad_q      = burst_q[1] || size_q[2];
    final_beat = (cnt == len_q);
    word       = addr_q[ADDR_WIDTH-1:3];
    step       = 32'd1 << size_q;
    if (burst_q == 2'd0) begin
      next_addr = addr_q;
    end else begin
      next_addr = (addr_q & ~(step - 32'd1)) + step;
    end
  end

  // Response outputs are driven straight from the held burst context so they
  // stay stable while the master stalls; everything is zero outside its phase.
  always_comb begin
    r_id   = '0;
    r_data = '0;
    r_resp = 2'b00;
    r_last = 1'b0;
    b_id   = '0;
    b_resp = 2'b00;
    if (state == RD_BURST) begin
      r_id   = id_q;
      r_data = bad_q ? 64'd0 : mem[word];
      r_resp = bad_q ? 2'b10 : 2'b00;
      r_last = final_beat;
    end
    if (state == WR_RESP) begin
      b_id   = id_q;
      b_resp = (bad_q || last_err) ? 2'b10 : 2'b00;
    end
  end

  // Transaction FSM: latches the accepted address phase, counts beats, steps
  // the address and tracks w_last misplacement for the write response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prio_wr  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt      <= '0;
      last_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          last_err <= 1'b0;
          if (ar_hs) begin
            id_q    <= ar_id;
            addr_q  <= ar_addr;
            len_q   <= ar_len;
            size_q  <= ar_size;
            burst_q <= ar_burst;
            prio_wr <= 1'b1;
            state   <= RD_BURST;
          end else if (aw_hs) begin
            id_q    <= aw_id;
            addr_q  <= aw_addr;
            len_q   <= aw_len;
            size_q  <= aw_size;
            burst_q <= aw_burst;
            prio_wr <= 1'b0;
            state   <= WR_DATA;
          end
        end
        RD_BURST: begin
          if (r_hs) begin
            addr_q <= next_addr;
            cnt    <= cnt + 8'd1;
            if (final_beat) begin
              state <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            addr_q <= next_addr;
            cnt    <= cnt + 8'd1;
            if (w_last != final_beat) begin
              last_err <= 1'b1;
            end
            if (final_beat) begin
              state <= WR_RESP;
            end
          end
        end
        default: begin
          if (b_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Byte-lane write into the memory array; contents survive reset, and bursts
  // with an unsupported type or size are never committed.
  always_ff @(posedge clock) begin
    if (w_hs && !bad_q) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strb[i]) begin
          mem[word][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed, scoreboard-based bench for axi4_mem_responder.
module tb_axi4_mem_responder;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [5:0] id;
  } bexp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] aw_addr = '0;
  logic [5:0]  aw_id = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [31:0] ar_addr = '0;
  logic [5:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [5:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int checks = 0;
  int errors = 0;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [63:0] ref_mem [int];
  logic [63:0] wbeat [0:15];

  axi4_mem_responder #(.ADDR_WIDTH(16), .ID_WIDTH(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference address stepping, 16-bit byte address space.
  function automatic logic [15:0] step_addr(input logic [15:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [15:0] inc;
    inc = 16'd1 << size;
    if (burst == 2'd0) return a;
    return (a & ~(inc - 16'd1)) + inc;
  endfunction

  function automatic logic [63:0] ref_read(input logic [15:0] a);
    int w;
    w = int'(a >> 3);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 64'hx;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [7:0] strb, input bit bad_last);
    logic [15:0] a;
    logic [63:0] cur;
    bit err;
    bexp_t be;
    int n;
    a = addr[15:0];
    err = burst[1] || size[2];
    @(negedge clock);
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
    #1; n = 0;
    while (!aw_ready && n < 50) begin @(negedge clock); #1; n++; end
    chk("aw_accept", aw_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    aw_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b != 0) @(negedge clock);
      w_valid = 1'b1; w_data = wbeat[b]; w_strb = strb;
      w_last = (b == int'(len)) && !bad_last;
      #1; n = 0;
      while (!w_ready && n < 50) begin @(negedge clock); #1; n++; end
      chk("w_accept", w_ready, 1'b1);
      @(posedge clock);
      if (!err) begin
        cur = ref_read(a);
        for (int i = 0; i < 8; i++) if (strb[i]) cur[8*i +: 8] = wbeat[b][8*i +: 8];
        ref_mem[int'(a >> 3)] = cur;
      end
      a = step_addr(a, size, burst);
    end
    be.id = id;
    be.resp = (err || bad_last) ? 2'b10 : 2'b00;
    bq.push_back(be);
    @(negedge clock);
    w_valid = 1'b0; w_last = 1'b0;
    chk("b_latency", b_valid, 1'b1);
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 50) begin @(negedge clock); n++; end
    be = bq.pop_front();
    chk("b_id", b_id, be.id);
    chk("b_resp", b_resp, be.resp);
    @(posedge clock);
    @(negedge clock);
    b_ready = 1'b0;
    chk("b_release", b_valid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] pat, input int abort_at);
    logic [15:0] a;
    bit err;
    rexp_t re;
    bit hs;
    int n, k, done, cyc;
    a = addr[15:0];
    err = burst[1] || size[2];
    for (int b = 0; b <= int'(len); b++) begin
      re.data = err ? 64'd0 : ref_read(a);
      re.resp = err ? 2'b10 : 2'b00;
      re.last = (b == int'(len));
      re.id = id;
      rq.push_back(re);
      a = step_addr(a, size, burst);
    end
    @(negedge clock);
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst;
    #1; n = 0;
    while (!ar_ready && n < 50) begin @(negedge clock); #1; n++; end
    chk("ar_accept", ar_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    ar_valid = 1'b0;
    chk("r_latency", r_valid, 1'b1);
    k = 0; done = 0; cyc = 0;
    while (rq.size() > 0 && cyc < 200) begin
      if (done == abort_at) begin
        chk("r_before_reset", r_valid, 1'b1);
        reset_n = 1'b0;
        r_ready = 1'b0;
        #1;
        chk("r_valid_in_reset", r_valid, 1'b0);
        chk("r_data_in_reset", r_data, 64'd0);
        rq.delete();
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      r_ready = pat[3 - (k % 4)];
      k++;
      re = rq[0];
      chk("r_valid", r_valid, 1'b1);
      chk("r_data", r_data, re.data);
      chk("r_resp", r_resp, re.resp);
      chk("r_last", r_last, re.last);
      chk("r_id", r_id, re.id);
      hs = r_valid && r_ready;
      @(posedge clock);
      if (hs) begin void'(rq.pop_front()); done++; end
      @(negedge clock);
      cyc++;
    end
    chk("r_beats_left", rq.size(), 0);
    rq.delete();
    r_ready = 1'b0;
    chk("r_end", r_valid, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    #3;
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_ar_ready", ar_ready, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_r_data", r_data, 64'd0);
    chk("rst_resps", {b_resp, r_resp, r_last}, 5'd0);
    chk("rst_ids", {b_id, r_id}, 12'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // INCR write/read burst at 0x100
    wbeat[0] = 64'h1111111111111111; wbeat[1] = 64'h2222222222222222;
    wbeat[2] = 64'h3333333333333333; wbeat[3] = 64'h4444444444444444;
    do_write(32'h100, 6'h05, 8'd3, 3'd3, 2'd1, 8'hFF, 1'b0);
    do_read(32'h100, 6'h2A, 8'd3, 3'd3, 2'd1, 4'b1111, -1);

    // Partial strobe merge
    wbeat[0] = 64'hFFFFFFFFFFFFFFFF;
    do_write(32'h200, 6'h01, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0);
    wbeat[0] = 64'hAAAAAAAABBBBBBBB;
    do_write(32'h200, 6'h02, 8'd0, 3'd3, 2'd1, 8'h0F, 1'b0);
    chk("merge_model", ref_read(16'h200), 64'hFFFFFFFFBBBBBBBB);
    do_read(32'h200, 6'h03, 8'd0, 3'd3, 2'd1, 4'b1111, -1);

    // Arbitration from a fresh reset: read first, then alternate
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    aw_valid = 1'b1; ar_valid = 1'b1; aw_addr = 32'h400; ar_addr = 32'h100;
    #1;
    chk("arb1_ar_ready", ar_ready, 1'b1);
    chk("arb1_aw_ready", aw_ready, 1'b0);
    aw_valid = 1'b0; ar_valid = 1'b0;
    do_read(32'h100, 6'h11, 8'd0, 3'd3, 2'd1, 4'b1111, -1);
    @(negedge clock);
    aw_valid = 1'b1; ar_valid = 1'b1;
    #1;
    chk("arb2_ar_ready", ar_ready, 1'b0);
    chk("arb2_aw_ready", aw_ready, 1'b1);
    aw_valid = 1'b0; ar_valid = 1'b0;
    wbeat[0] = 64'h0BADF00D12345678;
    do_write(32'h400, 6'h12, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0);
    @(negedge clock);
    aw_valid = 1'b1; ar_valid = 1'b1;
    #1;
    chk("arb3_ar_ready", ar_ready, 1'b1);
    chk("arb3_aw_ready", aw_ready, 1'b0);
    aw_valid = 1'b0; ar_valid = 1'b0;

    // Long read with r_ready backpressure 1,0,0,1
    for (int i = 0; i < 8; i++) wbeat[i] = 64'h0101010101010101 * 64'(i + 1);
    do_write(32'h500, 6'h07, 8'd7, 3'd3, 2'd1, 8'hFF, 1'b0);
    do_read(32'h500, 6'h08, 8'd7, 3'd3, 2'd1, 4'b1001, -1);

    // Unsupported burst type: SLVERR, memory untouched; FIXED read repeats
    wbeat[0] = 64'h0123456789ABCDEF;
    do_write(32'h300, 6'h09, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0);
    wbeat[0] = 64'hDEADBEEFDEADBEEF;
    do_write(32'h300, 6'h0A, 8'd0, 3'd3, 2'd2, 8'hFF, 1'b0);
    do_read(32'h300, 6'h0B, 8'd0, 3'd3, 2'd1, 4'b1111, -1);
    wbeat[0] = 64'hCAFEBABE00C0FFEE;
    do_write(32'h308, 6'h0C, 8'd0, 3'd3, 2'd1, 8'hFF, 1'b0);
    do_read(32'h308, 6'h0D, 8'd2, 3'd3, 2'd0, 4'b1111, -1);

    // Oversized beat size gives SLVERR with zero data on every beat
    do_read(32'h100, 6'h0E, 8'd1, 3'd4, 2'd1, 4'b1111, -1);

    // Misplaced w_last: SLVERR but data still committed
    wbeat[0] = 64'h5555AAAA5555AAAA; wbeat[1] = 64'h6666BBBB6666BBBB;
    do_write(32'h600, 6'h0F, 8'd1, 3'd3, 2'd1, 8'hFF, 1'b1);
    do_read(32'h600, 6'h10, 8'd1, 3'd3, 2'd1, 4'b1111, -1);

    // Address wrap past the top of memory
    wbeat[0] = 64'h7777777777777777; wbeat[1] = 64'h8888888888888888;
    do_write(32'hFFF8, 6'h13, 8'd1, 3'd3, 2'd1, 8'hFF, 1'b0);
    do_read(32'hFFF8, 6'h14, 8'd1, 3'd3, 2'd1, 4'b1111, -1);

    // Reset in the middle of a read burst, then data survives
    do_read(32'h100, 6'h15, 8'd3, 3'd3, 2'd1, 4'b1111, 2);
    @(negedge clock);
    chk("post_reset_r_valid", r_valid, 1'b0);
    do_read(32'h100, 6'h16, 8'd3, 3'd3, 2'd1, 4'b1111, -1);
    do_read(32'h0001_0100, 6'h17, 8'd0, 3'd3, 2'd1, 4'b1111, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
